// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns
// for hex digits 0..f, the scan FSM state type and small one-hot helpers.
package seg7_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] PAT_0 = 7'h3f;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5b;
    localparam logic [6:0] PAT_3 = 7'h4f;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6d;
    localparam logic [6:0] PAT_6 = 7'h7d;
    localparam logic [6:0] PAT_7 = 7'h27;
    localparam logic [6:0] PAT_8 = 7'h7f;
    localparam logic [6:0] PAT_9 = 7'h6f;
    localparam logic [6:0] PAT_A = 7'h5f;
    localparam logic [6:0] PAT_B = 7'h7c;
    localparam logic [6:0] PAT_C = 7'h58;
    localparam logic [6:0] PAT_D = 7'h5e;
    localparam logic [6:0] PAT_E = 7'h7b;
    localparam logic [6:0] PAT_F = 7'h71;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_HOLD
    } state_t;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_pat2hex.sv
// Combinational segment-pattern to hex-nibble decoder.
// Ports: pattern (7-bit g..a) in; nibble (4-bit) and bad (unknown pattern) out.
module seg7_pat2hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       bad
);

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        unique case (pattern)
            PAT_0:   nibble = 4'h0;
            PAT_1:   nibble = 4'h1;
            PAT_2:   nibble = 4'h2;
            PAT_3:   nibble = 4'h3;
            PAT_4:   nibble = 4'h4;
            PAT_5:   nibble = 4'h5;
            PAT_6:   nibble = 4'h6;
            PAT_7:   nibble = 4'h7;
            PAT_8:   nibble = 4'h8;
            PAT_9:   nibble = 4'h9;
            PAT_A:   nibble = 4'ha;
            PAT_B:   nibble = 4'hb;
            PAT_C:   nibble = 4'hc;
            PAT_D:   nibble = 4'hd;
            PAT_E:   nibble = 4'he;
            PAT_F:   nibble = 4'hf;
            default: bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 8-digit seven-segment display bus and rebuilds the
// shown hex frame. Ports: i_clk, i_rstn (sync, active-low), i_seg_d, i_seg_com
// in; o_value, o_dots, o_valid, o_err, o_timeout out.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_seg_d,
    input  logic [7:0]  i_seg_com,
    output logic [31:0] o_value,
    output logic [7:0]  o_dots,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_timeout
);

    localparam logic [7:0]  STB = 8'(STABLE_CYC);
    localparam logic [24:0] TMO = 25'(TIMEOUT_CYC);

    logic [7:0]  s_d, s_com, p_d, p_com;
    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        capture, same, onehot;
    logic [24:0] idle;
    logic [3:0]  nib;
    logic        bad_pat;
    logic [2:0]  dig;
    logic [31:0] acc_value, value_new;
    logic [7:0]  acc_dots, dots_new;
    logic [7:0]  seen, seen_new, bad, bad_new;

    seg7_pat2hex u_pat2hex (
        .pattern (s_d[6:0]),
        .nibble  (nib),
        .bad     (bad_pat)
    );

    // s_* is the sample stage; p_* is the sample before it, for change detect.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s_d   <= 8'd0;
            s_com <= 8'd0;
            p_d   <= 8'd0;
            p_com <= 8'd0;
        end else begin
            s_d   <= i_seg_d;
            s_com <= i_seg_com;
            p_d   <= s_d;
            p_com <= s_com;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= S_WAIT;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign same   = ({s_com, s_d} == {p_com, p_d});
    assign onehot = is_onehot(s_com);
    assign dig    = onehot_idx(s_com);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (onehot) begin
                    state_nx = S_SETTLE;
                    cnt_nx   = 8'd1;
                end
            end
            S_SETTLE, S_HOLD: begin
                if (!same) begin
                    state_nx = onehot ? S_SETTLE : S_WAIT;
                    cnt_nx   = onehot ? 8'd1 : 8'd0;
                end else if (state == S_SETTLE) begin
                    cnt_nx = cnt + 8'd1;
                    // This sample is the STABLE_CYC-th identical one.
                    if (cnt == STB - 8'd1) begin
                        capture  = 1'b1;
                        state_nx = S_HOLD;
                    end
                end
            end
            default: begin
                state_nx = S_WAIT;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_comb begin
        value_new = acc_value;
        dots_new  = acc_dots;
        bad_new   = bad;
        value_new[{dig, 2'b00} +: 4] = nib;
        dots_new[dig] = s_d[7];
        bad_new[dig]  = bad_pat;
    end

    assign seen_new = seen | s_com;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            acc_value <= 32'd0;
            acc_dots  <= 8'd0;
            seen      <= 8'd0;
            bad       <= 8'd0;
            idle      <= 25'd0;
            o_value   <= 32'd0;
            o_dots    <= 8'd0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            if (capture) begin
                // Capture has priority over a coincident timeout.
                idle      <= 25'd0;
                acc_value <= value_new;
                acc_dots  <= dots_new;
                if (seen_new == 8'hff) begin
                    o_valid <= 1'b1;
                    o_value <= value_new;
                    o_dots  <= dots_new;
                    o_err   <= |bad_new;
                    seen    <= 8'd0;
                    bad     <= 8'd0;
                end else begin
                    seen <= seen_new;
                    bad  <= bad_new;
                end
            end else if (idle != TMO) begin
                idle <= idle + 25'd1;
                if (idle == TMO - 25'd1 && seen != 8'd0) begin
                    o_timeout <= 1'b1;
                    seen      <= 8'd0;
                    bad       <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed frames push expected
// results; a monitor pops and compares on each o_valid / o_timeout pulse.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rstn;
    logic [7:0]  seg_d;
    logic [7:0]  seg_com;
    logic [31:0] value;
    logic [7:0]  dots;
    logic        valid;
    logic        err;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_to;
        logic [31:0] val;
        logic [7:0]  dts;
        logic        er;
    } exp_t;

    exp_t q[$];

    localparam logic [6:0] PAT [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
        7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71
    };

    seg7_scan_decoder #(
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_seg_d   (seg_d),
        .i_seg_com (seg_com),
        .o_value   (value),
        .o_dots    (dots),
        .o_valid   (valid),
        .o_err     (err),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] need);
        n_cmp++;
        if (got !== need) begin
            n_bad++;
            $display("FAIL %s: got %h need %h", name, got, need);
        end
    endtask

    task automatic push_valid(input logic [31:0] v, input logic [7:0] d,
                              input logic e);
        exp_t x;
        x.is_to = 1'b0;
        x.val   = v;
        x.dts   = d;
        x.er    = e;
        q.push_back(x);
    endtask

    task automatic push_timeout();
        exp_t x;
        x.is_to = 1'b1;
        x.val   = 32'd0;
        x.dts   = 8'd0;
        x.er    = 1'b0;
        q.push_back(x);
    endtask

    task automatic drive(input int d, input logic [6:0] p, input logic dot,
                         input int n);
        @(negedge clk);
        seg_com = 8'd1 << d;
        seg_d   = {dot, p};
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        seg_com = 8'd0;
        seg_d   = 8'd0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Drives cnt digits starting at digit first (wrapping), 6 cycles each.
    task automatic digits(input logic [31:0] v, input logic [7:0] dt,
                          input logic [7:0] badm, input int first,
                          input int cnt);
        int d;
        logic [3:0] nb;
        for (int j = 0; j < cnt; j++) begin
            d  = (first + j) % 8;
            nb = v[4*d +: 4];
            drive(d, badm[d] ? 7'h00 : PAT[nb], dt[d], 6);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid) begin
                if (q.size() == 0 || q[0].is_to) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got value=%h need none",
                             value);
                end else begin
                    e = q.pop_front();
                    chk("value", value, e.val);
                    chk("dots", {24'd0, dots}, {24'd0, e.dts});
                    chk("err", {31'd0, err}, {31'd0, e.er});
                end
            end
            if (timeout) begin
                n_cmp++;
                if (q.size() == 0 || !q[0].is_to) begin
                    n_bad++;
                    $display("FAIL unexpected_timeout: got pulse need none");
                end else begin
                    e = q.pop_front();
                end
            end
        end
    end

    initial begin
        rstn    = 1'b0;
        seg_d   = 8'd0;
        seg_com = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_value", value, 32'd0);
        chk("rst_dots", {24'd0, dots}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        rstn = 1'b1;
        idle(4);

        // Full frame, dot on digit 3.
        push_valid(32'h76543210, 8'h08, 1'b0);
        digits(32'h76543210, 8'h08, 8'h00, 0, 8);
        idle(5);

        // Non-one-hot common: nothing may be captured.
        @(negedge clk);
        seg_com = 8'h03;
        seg_d   = {1'b0, PAT[5]};
        repeat (19) @(negedge clk);
        idle(5);

        // Glitch: 06 held 3 cycles is dropped, 3f held 4 cycles is taken.
        push_valid(32'h76543210, 8'h00, 1'b0);
        drive(0, 7'h06, 1'b0, 3);
        drive(0, 7'h3f, 1'b0, 4);
        digits(32'h76543210, 8'h00, 8'h00, 1, 7);
        idle(5);

        // Bad pattern on digit 5.
        push_valid(32'hfe0cba98, 8'h81, 1'b1);
        digits(32'hfedcba98, 8'h81, 8'h20, 0, 8);
        idle(5);

        // Error flag must not persist into the next frame.
        push_valid(32'h6789abcd, 8'h00, 1'b0);
        digits(32'h6789abcd, 8'h00, 8'h00, 0, 8);
        idle(5);

        // Partial frame with a bad digit, then timeout.
        push_timeout();
        digits(32'h00000321, 8'h00, 8'h02, 0, 3);
        idle(30);
        chk("timeout_seen", 32'(q.size()), 32'd0);

        // Fresh frame in rotated order reports only new data.
        push_valid(32'h13579bdf, 8'h10, 1'b0);
        digits(32'h13579bdf, 8'h10, 8'h00, 3, 8);
        idle(5);

        // Mid-frame reset after 4 captures.
        digits(32'h0000abcd, 8'h0f, 8'h04, 0, 4);
        @(negedge clk);
        rstn    = 1'b0;
        seg_com = 8'd0;
        seg_d   = 8'd0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_rst_value", value, 32'd0);
        chk("mid_rst_dots", {24'd0, dots}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        idle(3);
        push_valid(32'h2468ace0, 8'h00, 1'b0);
        digits(32'h2468ace0, 8'h00, 8'h00, 4, 8);
        idle(30);

        chk("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
